// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: key-schedule FSM states, round constants and the
// S-box byte substitution, also used by the SubBytes datapath.
package aes128_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } key_state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Index 0 and 11..15 are unused padding so any 4-bit round index is safe.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel S-box lookups, purely combinational.
module aes_sub_word
    import aes128_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    assign result = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes128_round_key_gen.sv
// On-the-fly AES-128 round-key generator, forward (0..10) or reverse (10..0) order.
// Optional round-10 key cache enabled by defining AES_KEYSCHED_CACHE_EN.
module aes128_round_key_gen
    import aes128_pkg::*;
(
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Start,
    input  logic [127:0] i_Key,
    input  logic         i_fDec,
    input  logic         i_Next,
    output logic [127:0] o_RoundKey,
    output logic [3:0]   o_Round,
    output logic         o_Valid,
    output logic         o_Last,
    output logic         o_Busy
);

    key_state_e   state_r;
    logic [127:0] key_r;
    logic [3:0]   round_r;
    logic         dec_r;
    logic         valid_r;
    logic         last_r;
    logic         busy_r;

    logic [31:0]  fwd_sub_s;
    logic [31:0]  fwd_w4_s;
    logic [31:0]  fwd_w5_s;
    logic [31:0]  fwd_w6_s;
    logic [31:0]  fwd_w7_s;
    logic [127:0] fwd_key_s;

    logic [31:0]  bwd_sub_s;
    logic [31:0]  bwd_w0_s;
    logic [31:0]  bwd_w1_s;
    logic [31:0]  bwd_w2_s;
    logic [31:0]  bwd_w3_s;
    logic [127:0] bwd_key_s;

    logic         cache_hit_s;
    logic [127:0] cache_key_s;

    // Forward step produces the key for round_r+1 from the key held in key_r.
    aes_sub_word u_fwd_sub (
        .word   (rot_word(key_r[31:0])),
        .result (fwd_sub_s)
    );

    assign fwd_w4_s  = key_r[127:96] ^ fwd_sub_s ^ {RCON[round_r + 4'd1], 24'h000000};
    assign fwd_w5_s  = key_r[95:64] ^ fwd_w4_s;
    assign fwd_w6_s  = key_r[63:32] ^ fwd_w5_s;
    assign fwd_w7_s  = key_r[31:0]  ^ fwd_w6_s;
    assign fwd_key_s = {fwd_w4_s, fwd_w5_s, fwd_w6_s, fwd_w7_s};

    // Backward step must recover w3 first: w0 depends on SubWord of the old w3.
    assign bwd_w3_s = key_r[31:0]  ^ key_r[63:32];
    assign bwd_w2_s = key_r[63:32] ^ key_r[95:64];
    assign bwd_w1_s = key_r[95:64] ^ key_r[127:96];

    aes_sub_word u_bwd_sub (
        .word   (rot_word(bwd_w3_s)),
        .result (bwd_sub_s)
    );

    assign bwd_w0_s  = key_r[127:96] ^ bwd_sub_s ^ {RCON[round_r], 24'h000000};
    assign bwd_key_s = {bwd_w0_s, bwd_w1_s, bwd_w2_s, bwd_w3_s};

`ifdef AES_KEYSCHED_CACHE_EN
    logic [127:0] tag_key_r;
    logic [127:0] tag_rk10_r;
    logic         tag_valid_r;

    assign cache_hit_s = tag_valid_r && (tag_key_r == i_Key);
    assign cache_key_s = tag_rk10_r;

    // Tag becomes valid only once an expansion completes; a fresh miss invalidates it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tag_key_r   <= 128'h0;
            tag_rk10_r  <= 128'h0;
            tag_valid_r <= 1'b0;
        end else if ((state_r == IDLE) && i_Start && i_fDec && !cache_hit_s) begin
            tag_key_r   <= i_Key;
            tag_valid_r <= 1'b0;
        end else if ((state_r == EXPAND) && (round_r == 4'd9)) begin
            tag_rk10_r  <= fwd_key_s;
            tag_valid_r <= 1'b1;
        end else begin
            tag_valid_r <= tag_valid_r;
        end
    end
`else
    assign cache_hit_s = 1'b0;
    assign cache_key_s = 128'h0;
`endif

    // Key-schedule FSM; all outputs are registered state.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r <= IDLE;
            key_r   <= 128'h0;
            round_r <= 4'd0;
            dec_r   <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    if (i_Start) begin
                        dec_r  <= i_fDec;
                        busy_r <= 1'b1;
                        if (!i_fDec) begin
                            key_r   <= i_Key;
                            round_r <= 4'd0;
                            state_r <= EMIT;
                        end else if (cache_hit_s) begin
                            key_r   <= cache_key_s;
                            round_r <= LAST_ROUND;
                            state_r <= EMIT;
                        end else begin
                            key_r   <= i_Key;
                            round_r <= 4'd0;
                            state_r <= EXPAND;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                EXPAND: begin
                    key_r   <= fwd_key_s;
                    round_r <= round_r + 4'd1;
                    if (round_r == 4'd9) begin
                        state_r <= EMIT;
                    end else begin
                        state_r <= EXPAND;
                    end
                end
                EMIT: begin
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        last_r  <= dec_r ? (round_r == 4'd0) : (round_r == LAST_ROUND);
                    end else if (i_Next) begin
                        if (last_r) begin
                            state_r <= IDLE;
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                        end else if (dec_r) begin
                            key_r   <= bwd_key_s;
                            round_r <= round_r - 4'd1;
                            last_r  <= (round_r == 4'd1);
                        end else begin
                            key_r   <= fwd_key_s;
                            round_r <= round_r + 4'd1;
                            last_r  <= (round_r == 4'd9);
                        end
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_RoundKey = key_r;
    assign o_Round    = round_r;
    assign o_Valid    = valid_r;
    assign o_Last     = last_r;
    assign o_Busy     = busy_r;

endmodule

// File: tb/tb_aes128_round_key_gen.sv
// Directed scoreboard bench for aes128_round_key_gen using the FIPS-197 key schedule.
module tb_aes128_round_key_gen;

    logic         i_Clk;
    logic         i_Rst;
    logic         i_Start;
    logic [127:0] i_Key;
    logic         i_fDec;
    logic         i_Next;
    logic [127:0] o_RoundKey;
    logic [3:0]   o_Round;
    logic         o_Valid;
    logic         o_Last;
    logic         o_Busy;

    typedef struct packed {
        logic [3:0]   round;
        logic [127:0] key;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] rk [0:10];
    int           n_checks;
    int           n_fail;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`ifdef AES_KEYSCHED_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 11;
`endif

    aes128_round_key_gen dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Start    (i_Start),
        .i_Key      (i_Key),
        .i_fDec     (i_fDec),
        .i_Next     (i_Next),
        .o_RoundKey (o_RoundKey),
        .o_Round    (o_Round),
        .o_Valid    (o_Valid),
        .o_Last     (o_Last),
        .o_Busy     (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_num(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_key(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk_bit({tag, "_valid"}, o_Valid, 1'b0);
        chk_bit({tag, "_last"}, o_Last, 1'b0);
        chk_bit({tag, "_busy"}, o_Busy, 1'b0);
        chk_num({tag, "_round"}, int'(o_Round), 0);
        chk_key({tag, "_key"}, o_RoundKey, 128'h0);
    endtask

    task automatic push_fips(input logic dec);
        for (int i = 0; i <= 10; i++) begin
            exp_t e;
            e.round = dec ? 4'(10 - i) : 4'(i);
            e.key   = rk[e.round];
            e.last  = (i == 10);
            sb.push_back(e);
        end
    endtask

    // Start a sequence and measure edges from the start edge to the first valid key.
    task automatic start_seq(input logic [127:0] key, input logic dec, input int exp_lat,
                             input int pulse_at, input bit push);
        int lat;
        i_Key   = key;
        i_fDec  = dec;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        chk_bit("busy_after_start", o_Busy, 1'b1);
        if (push) push_fips(dec);
        lat = 0;
        while (!o_Valid && lat < 40) begin
            if (lat == pulse_at) begin
                i_Start = 1'b1;
                i_Key   = ~key;
            end else begin
                i_Start = 1'b0;
                i_Key   = key;
            end
            tick();
            lat++;
        end
        i_Start = 1'b0;
        i_Key   = key;
        chk_num("first_key_latency", lat, exp_lat);
    endtask

    // Compare the presented key against the scoreboard while held, then accept it.
    task automatic consume(input int hold);
        exp_t e;
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk_bit("valid", o_Valid, 1'b1);
            chk_num("round", int'(o_Round), int'(e.round));
            chk_key("round_key", o_RoundKey, e.key);
            chk_bit("last", o_Last, e.last);
            if (h < hold) begin
                i_Next = 1'b0;
                tick();
            end
        end
        i_Next = 1'b1;
        tick();
    endtask

    task automatic check_done();
        i_Next = 1'b0;
        chk_bit("done_valid", o_Valid, 1'b0);
        chk_bit("done_last", o_Last, 1'b0);
        chk_bit("done_busy", o_Busy, 1'b0);
    endtask

    initial begin
        exp_t z;
        n_checks = 0;
        n_fail   = 0;
        rk[0]  = FIPS_KEY;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        i_Rst   = 1'b1;
        i_Start = 1'b0;
        i_Key   = 128'h0;
        i_fDec  = 1'b0;
        i_Next  = 1'b0;
        tick();
        tick();
        chk_zero_outputs("reset");
        i_Rst = 1'b0;
        tick();

        // Forward order, back-to-back accepts.
        start_seq(FIPS_KEY, 1'b0, 1, -1, 1'b1);
        repeat (11) consume(0);
        check_done();
        tick();

        // Reverse order, i_Start pulsed mid-expansion.
        start_seq(FIPS_KEY, 1'b1, 11, 3, 1'b1);
        repeat (11) consume(0);
        check_done();
        tick();

        // Reverse order again with the same key, throttled accepts, i_Start pulsed mid-emission.
        start_seq(FIPS_KEY, 1'b1, HIT_LAT, -1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i == 5) begin
                i_Start = 1'b1;
                i_Key   = 128'h0;
                i_fDec  = 1'b0;
            end
            consume(2);
            i_Start = 1'b0;
            i_Key   = FIPS_KEY;
            i_fDec  = 1'b1;
        end
        check_done();
        tick();

        // A different key must expand in full, then reset abandons it.
        start_seq(128'h0, 1'b1, 11, -1, 1'b0);
        chk_num("other_key_round", int'(o_Round), 10);
        chk_bit("other_key_last", o_Last, 1'b0);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        chk_zero_outputs("rst_after_expand");

        // Zero key forward, reset mid-emission.
        z.round = 4'd0; z.key = 128'h0; z.last = 1'b0;
        sb.push_back(z);
        z.round = 4'd1; z.key = 128'h62636363626363636263636362636363; z.last = 1'b0;
        sb.push_back(z);
        start_seq(128'h0, 1'b0, 1, -1, 1'b0);
        consume(0);
        consume(0);
        chk_num("zero_key_round2_shown", int'(o_Round), 2);
        i_Next = 1'b0;
        i_Rst  = 1'b1;
        tick();
        i_Rst = 1'b0;
        chk_zero_outputs("rst_mid_emit");
        tick();

        // Clean restart after reset: no cached key survives.
        start_seq(FIPS_KEY, 1'b1, 11, -1, 1'b1);
        repeat (11) consume(0);
        check_done();
        chk_num("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
